// File: rtl/sel_strobe_latch_pkg.sv
// Shared definitions for the select-strobe latch: channel FSM encoding and filter limits.
package sel_strobe_latch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HELD = 2'd2
    } ch_state_e;

    localparam int FILT_MIN = 1;
    localparam int FILT_MAX = 15;

    // Clamp a requested filter length into the supported range.
    function automatic int filt_clamp(input int filt);
        if (filt < FILT_MIN) begin
            return FILT_MIN;
        end else if (filt > FILT_MAX) begin
            return FILT_MAX;
        end else begin
            return filt;
        end
    endfunction

endpackage

// File: rtl/sel_strobe_latch_if.sv
// Bus between the select-strobe latch and its environment: decoder selects, data, clear and results.
interface sel_strobe_latch_if #(
    parameter int WIDTH_SEL = 8
);
    logic [WIDTH_SEL-1:0] Y_n;
    logic                 D;
    logic                 CLR_n;
    logic [WIDTH_SEL-1:0] sel_strobe;
    logic [WIDTH_SEL-1:0] latch_q;
    logic                 busy;
    logic                 multi_err;

    modport master (
        output Y_n, D, CLR_n,
        input  sel_strobe, latch_q, busy, multi_err
    );

    modport slave (
        input  Y_n, D, CLR_n,
        output sel_strobe, latch_q, busy, multi_err
    );
endinterface

// File: rtl/sel_filter_ch.sv
// One select channel: 2-flop synchronizer, saturating low-time counter and IDLE/ARM/HELD qualifier.
module sel_filter_ch
    import sel_strobe_latch_pkg::*;
#(
    parameter int FILT = 2
) (
    input  logic clk,
    input  logic RESETn,
    input  logic y_n,
    output logic strobe_d,
    output logic held_d
);
    localparam int FILT_C = filt_clamp(FILT);
    localparam int CNT_W  = $clog2(FILT_C + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_C);

    logic             y_s1_q, y_s1_d;
    logic             ys_n_q, ys_n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ch_state_e        state_q, state_d;

    // Next-state logic; qualification uses the count being loaded this edge so the strobe lands FILT+2 clocks after the select.
    always_comb begin
        y_s1_d  = y_n;
        ys_n_d  = y_s1_q;
        cnt_d   = cnt_q;
        state_d = state_q;

        if (ys_n_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (ys_n_q) begin
                    state_d = IDLE;
                end else if (cnt_d == CNT_MAX) begin
                    state_d = HELD;
                end else begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (ys_n_q) begin
                    state_d = IDLE;
                end else if (cnt_d == CNT_MAX) begin
                    state_d = HELD;
                end else begin
                    state_d = ARM;
                end
            end
            HELD: begin
                if (ys_n_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = IDLE;
        endcase

        strobe_d = (state_q != HELD) && (state_d == HELD);
        held_d   = (state_d == HELD);
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            y_s1_q  <= 1'b1;
            ys_n_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            y_s1_q  <= y_s1_d;
            ys_n_q  <= ys_n_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/sel_strobe_latch.sv
// Filtered decoder-select strobes driving a 74LS259-style addressable latch with a sticky multi-select flag.
module sel_strobe_latch
    import sel_strobe_latch_pkg::*;
#(
    parameter int WIDTH_SEL = 8,
    parameter int FILT      = 2
) (
    input  logic               clk,
    input  logic               RESETn,
    sel_strobe_latch_if.slave  bus
);
    logic [WIDTH_SEL-1:0] strobe_vec_s;
    logic [WIDTH_SEL-1:0] held_vec_s;

    logic                 d_s1_q, d_s1_d;
    logic                 ds_q, ds_d;
    logic [WIDTH_SEL-1:0] sel_strobe_q, sel_strobe_d;
    logic [WIDTH_SEL-1:0] latch_q, latch_d;
    logic                 busy_q, busy_d;
    logic                 multi_err_q, multi_err_d;

    function automatic logic multi_hot(input logic [WIDTH_SEL-1:0] v);
        return (v & (v - {{(WIDTH_SEL-1){1'b0}}, 1'b1})) != '0;
    endfunction

    for (genvar i = 0; i < WIDTH_SEL; i++) begin : g_ch
        sel_filter_ch #(.FILT(FILT)) u_ch (
            .clk      (clk),
            .RESETn   (RESETn),
            .y_n      (bus.Y_n[i]),
            .strobe_d (strobe_vec_s[i]),
            .held_d   (held_vec_s[i])
        );
    end

    // Latch write and error tracking; clear wins over any strobe write in the same cycle.
    always_comb begin
        d_s1_d       = bus.D;
        ds_d         = d_s1_q;
        sel_strobe_d = strobe_vec_s;
        busy_d       = |held_vec_s;
        latch_d      = latch_q;
        multi_err_d  = multi_err_q;

        if (!bus.CLR_n) begin
            latch_d     = '0;
            multi_err_d = 1'b0;
        end else begin
            for (int i = 0; i < WIDTH_SEL; i++) begin
                if (strobe_vec_s[i]) begin
                    latch_d[i] = ds_q;
                end else begin
                    latch_d[i] = latch_q[i];
                end
            end
            if (multi_hot(strobe_vec_s)) begin
                multi_err_d = 1'b1;
            end else begin
                multi_err_d = multi_err_q;
            end
        end
    end

    // Output and data-synchronizer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            d_s1_q       <= 1'b0;
            ds_q         <= 1'b0;
            sel_strobe_q <= '0;
            latch_q      <= '0;
            busy_q       <= 1'b0;
            multi_err_q  <= 1'b0;
        end else begin
            d_s1_q       <= d_s1_d;
            ds_q         <= ds_d;
            sel_strobe_q <= sel_strobe_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
            multi_err_q  <= multi_err_d;
        end
    end

    assign bus.sel_strobe = sel_strobe_q;
    assign bus.latch_q    = latch_q;
    assign bus.busy       = busy_q;
    assign bus.multi_err  = multi_err_q;

endmodule
